// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the bittyCore pipeline control unit.
package pipe_ctrl_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned STALL_W = 3;
    localparam int unsigned WD_W    = 16;

    // Stall vector: bit0 = ID/EX bubble, bit1 = IF/ID hold, bit2 = PC hold
    localparam logic [STALL_W-1:0] STALL_NONE  = 3'b000;
    localparam logic [STALL_W-1:0] STALL_FETCH = 3'b110;
    localparam logic [STALL_W-1:0] STALL_ALL   = 3'b111;

    typedef enum logic [1:0] {
        CTRL_RUN  = 2'b00,
        CTRL_PEND = 2'b01
    } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stall-request, branch, redirect and debug signals between the pipeline and pipe_ctrl.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic                stallreq_if_i;
    logic                stallreq_id_i;
    logic                stallreq_ex_i;
    logic                ex_branch_flag_i;
    logic [ADDR_W-1:0]   ex_branch_addr_i;
    logic                timeout_clr_i;
    logic [STALL_W-1:0]  stalled_o;
    logic                flush_o;
    logic                redirect_o;
    logic [ADDR_W-1:0]   redirect_addr_o;
    logic                timeout_o;
    logic [CNT_W-1:0]    stall_cnt_o;
    logic [CNT_W-1:0]    flush_cnt_o;

    // Pipeline side
    modport master (
        output stallreq_if_i, stallreq_id_i, stallreq_ex_i,
               ex_branch_flag_i, ex_branch_addr_i, timeout_clr_i,
        input  stalled_o, flush_o, redirect_o, redirect_addr_o,
               timeout_o, stall_cnt_o, flush_cnt_o
    );

    // Controller side
    modport slave (
        input  stallreq_if_i, stallreq_id_i, stallreq_ex_i,
               ex_branch_flag_i, ex_branch_addr_i, timeout_clr_i,
        output stalled_o, flush_o, redirect_o, redirect_addr_o,
               timeout_o, stall_cnt_o, flush_cnt_o
    );

endinterface

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Counts consecutive stalled cycles and raises a sticky flag once the limit is hit.
module stall_watchdog
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned STALL_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    input  logic clr,
    output logic timeout
);

    localparam logic [WD_W-1:0] WD_LIM = WD_W'(STALL_TIMEOUT - 1);

    logic [WD_W-1:0] wd_cnt;

    // Clear beats a simultaneous set; counter saturates at the limit
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else if (stall) begin
            if (wd_cnt == WD_LIM) begin
                timeout <= 1'b1;
            end else begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
        end else begin
            wd_cnt <= '0;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/redirect controller with stall statistics and watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned STALL_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    ctrl_state_e         state_q, state_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
    logic [CNT_W-1:0]    stall_cnt_q, flush_cnt_q;
    logic [STALL_W-1:0]  stall_raw, stalled;
    logic                flush, redirect, accept;
    logic [ADDR_W-1:0]   redirect_addr;
    logic                any_stall;
    logic                timeout;

    assign any_stall = bus.stallreq_if_i | bus.stallreq_id_i | bus.stallreq_ex_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CTRL_RUN;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    // Next state and all combinational outputs; everything reads 0 under reset
    always_comb begin
        state_d       = state_q;
        pend_addr_d   = pend_addr_q;
        flush         = 1'b0;
        redirect      = 1'b0;
        redirect_addr = '0;
        accept        = 1'b0;
        stall_raw     = STALL_NONE;
        stalled       = STALL_NONE;

        if (!rst) begin
            if (bus.stallreq_ex_i || bus.stallreq_id_i) begin
                stall_raw = STALL_ALL;
            end else if (bus.stallreq_if_i) begin
                stall_raw = STALL_FETCH;
            end

            case (state_q)
                CTRL_RUN: begin
                    if (bus.ex_branch_flag_i) begin
                        flush  = 1'b1;
                        accept = 1'b1;
                        if (!bus.stallreq_if_i) begin
                            redirect      = 1'b1;
                            redirect_addr = bus.ex_branch_addr_i;
                        end else begin
                            pend_addr_d = bus.ex_branch_addr_i;
                            state_d     = CTRL_PEND;
                        end
                    end
                end
                CTRL_PEND: begin
                    // Branch flag ignored here: the flush keeps EX empty
                    flush         = 1'b1;
                    redirect_addr = pend_addr_q;
                    if (!bus.stallreq_if_i) begin
                        redirect = 1'b1;
                        state_d  = CTRL_RUN;
                    end
                end
                default: state_d = CTRL_RUN;
            endcase

            stalled = flush ? {stall_raw[2:1], 1'b0} : stall_raw;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stalled != STALL_NONE) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (accept)                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    stall_watchdog #(
        .STALL_TIMEOUT(STALL_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .stall   (any_stall),
        .clr     (bus.timeout_clr_i),
        .timeout (timeout)
    );

    assign bus.stalled_o       = stalled;
    assign bus.flush_o         = flush;
    assign bus.redirect_o      = redirect;
    assign bus.redirect_addr_o = redirect_addr;
    assign bus.timeout_o       = timeout;
    assign bus.stall_cnt_o     = stall_cnt_q;
    assign bus.flush_cnt_o     = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus queues expected values, a negedge monitor checks them.
module tb_pipe_ctrl;

    localparam int K_STALL = 0;
    localparam int K_FLUSH = 1;
    localparam int K_REDIR = 2;
    localparam int K_ADDR  = 3;
    localparam int K_TOUT  = 4;
    localparam int K_SCNT  = 5;
    localparam int K_FCNT  = 6;

    typedef struct {
        string       name;
        int          cyc;
        int          kind;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    pipe_ctrl_if bus();

    pipe_ctrl #(.STALL_TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int k);
        case (k)
            K_STALL: return 32'(bus.stalled_o);
            K_FLUSH: return 32'(bus.flush_o);
            K_REDIR: return 32'(bus.redirect_o);
            K_ADDR:  return bus.redirect_addr_o;
            K_TOUT:  return 32'(bus.timeout_o);
            K_SCNT:  return bus.stall_cnt_o;
            default: return bus.flush_cnt_o;
        endcase
    endfunction

    // Monitor: consume every expectation due in the current cycle
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] a;
            e = sb.pop_front();
            a = actual(e.kind);
            n_cmp++;
            if (e.cyc != cyc || a !== e.val) begin
                n_bad++;
                $display("FAIL %s (cycle %0d/%0d): got 0x%0h, want 0x%0h", e.name, e.cyc, cyc, a, e.val);
            end
        end
    end

    task automatic drive(input logic r, input logic sif, input logic sid, input logic sex,
                         input logic br, input logic [31:0] ba, input logic clr);
        @(posedge clk);
        #1;
        rst                  = r;
        bus.stallreq_if_i    = sif;
        bus.stallreq_id_i    = sid;
        bus.stallreq_ex_i    = sex;
        bus.ex_branch_flag_i = br;
        bus.ex_branch_addr_i = ba;
        bus.timeout_clr_i    = clr;
    endtask

    task automatic chk(input string n, input int k, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.cyc  = cyc;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        bus.stallreq_if_i    = 1'b0;
        bus.stallreq_id_i    = 1'b0;
        bus.stallreq_ex_i    = 1'b0;
        bus.ex_branch_flag_i = 1'b0;
        bus.ex_branch_addr_i = 32'h0;
        bus.timeout_clr_i    = 1'b0;

        // Reset with random inputs: all combinational outputs forced low
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom, 1'($urandom));
            chk("rst_stalled", K_STALL, 32'h0);
            chk("rst_flush",   K_FLUSH, 32'h0);
            chk("rst_redir",   K_REDIR, 32'h0);
            chk("rst_addr",    K_ADDR,  32'h0);
        end
        idle();
        chk("post_rst_scnt", K_SCNT, 32'd0);
        chk("post_rst_fcnt", K_FCNT, 32'd0);
        chk("post_rst_tout", K_TOUT, 32'd0);
        chk("post_rst_stalled", K_STALL, 32'h0);

        // Stall priority
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0); chk("prio_id",   K_STALL, 32'h7);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0); chk("prio_if",   K_STALL, 32'h6);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0); chk("prio_all",  K_STALL, 32'h7);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0); chk("prio_ex",   K_STALL, 32'h7);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0); chk("prio_if2",  K_STALL, 32'h6);
        idle();
        chk("scnt_5", K_SCNT, 32'd5);
        chk("idle_stalled", K_STALL, 32'h0);

        // Branch with fetch free
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0);
        chk("br_flush", K_FLUSH, 32'h1);
        chk("br_redir", K_REDIR, 32'h1);
        chk("br_addr",  K_ADDR,  32'h100);
        chk("br_stalled", K_STALL, 32'h0);
        idle();
        chk("br_fcnt1", K_FCNT, 32'd1);
        chk("br_redir_off", K_REDIR, 32'h0);
        chk("br_addr_off",  K_ADDR,  32'h0);
        // Branch coinciding with an ID hazard: flush drops the bubble bit
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0104, 1'b0);
        chk("br_id_stalled", K_STALL, 32'h6);
        chk("br_id_addr",    K_ADDR,  32'h104);
        idle();
        chk("br_fcnt2", K_FCNT, 32'd2);
        chk("br_scnt6", K_SCNT, 32'd6);

        // Branch during fetch stall; second branch pulse in PEND is ignored
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_2000, 1'b0);
        chk("pend0_flush", K_FLUSH, 32'h1);
        chk("pend0_redir", K_REDIR, 32'h0);
        chk("pend0_addr",  K_ADDR,  32'h0);
        chk("pend0_stalled", K_STALL, 32'h6);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEC, 1'b0);
        chk("pend1_flush", K_FLUSH, 32'h1);
        chk("pend1_redir", K_REDIR, 32'h0);
        chk("pend1_addr",  K_ADDR,  32'h2000);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("pend2_flush", K_FLUSH, 32'h1);
        chk("pend2_redir", K_REDIR, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("pend3_flush", K_FLUSH, 32'h1);
        chk("pend3_redir", K_REDIR, 32'h1);
        chk("pend3_addr",  K_ADDR,  32'h2000);
        idle();
        chk("pend4_flush", K_FLUSH, 32'h0);
        chk("pend4_redir", K_REDIR, 32'h0);
        chk("pend4_fcnt",  K_FCNT,  32'd3);
        chk("pend4_scnt",  K_SCNT,  32'd9);

        // Watchdog: two 7-cycle runs never time out
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 7; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            idle();
            chk("wd7_tout", K_TOUT, 32'h0);
        end
        chk("wd7_scnt", K_SCNT, 32'd23);
        // Eight stalled cycles set the flag at the eighth edge
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("wd8_before", K_TOUT, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("wd8_set", K_TOUT, 32'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("wd_clr_wins", K_TOUT, 32'h0);
        idle();
        chk("wd_clr_hold", K_TOUT, 32'h0);
        chk("wd_scnt", K_SCNT, 32'd33);

        // Reset mid-PEND abandons the redirect
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_3000, 1'b0);
        chk("rp_flush", K_FLUSH, 32'h1);
        chk("rp_redir", K_REDIR, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("rp_rst_flush", K_FLUSH, 32'h0);
        idle();
        chk("rp_after_redir", K_REDIR, 32'h0);
        chk("rp_after_flush", K_FLUSH, 32'h0);
        chk("rp_after_addr",  K_ADDR,  32'h0);
        chk("rp_after_fcnt",  K_FCNT,  32'd0);
        idle();
        chk("rp_after2_redir", K_REDIR, 32'h0);
        chk("rp_after2_flush", K_FLUSH, 32'h0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
